alu_muldiv_seq: RTL and testbench

- Multi-cycle unsigned multiply/divide sequencer that borrows the shared ALU instead of instantiating its own adder.
- Requests the ALU with a req/gnt handshake and issues one add or subtract per iteration; all shifting happens in its own registers.
- Returns a 2*DW-bit product, or a quotient and remainder, with a done pulse.
- Sits beside the CPU core; the core's ALU input mux selects this block while alu_gnt is high.

---
 rtl/alu_muldiv_seq_if.sv | 29 ++
 rtl/alu_muldiv_seq.sv | 156 +++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
// rtl/alu_muldiv_seq_if.sv - shared-ALU borrow bus between the mul/div sequencer and the core ALU
interface alu_muldiv_seq_if #(
    parameter int DW = 16
);
    logic          alu_req;
    logic          alu_gnt;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_ai;
    logic [DW-1:0] alu_bi;
    logic          alu_ci;
    logic          alu_right;
    logic          alu_rotate;
    logic [3:0]    alu_ei;
    logic          alu_rdy;
    logic [DW-1:0] alu_out;
    logic          alu_co;

    modport master (
        output alu_req, alu_op, alu_ai, alu_bi, alu_ci,
               alu_right, alu_rotate, alu_ei, alu_rdy,
        input  alu_gnt, alu_out, alu_co
    );

    modport slave (
        input  alu_req, alu_op, alu_ai, alu_bi, alu_ci,
               alu_right, alu_rotate, alu_ei, alu_rdy,
        output alu_gnt, alu_out, alu_co
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - unsigned shift-add multiply / restoring divide using the borrowed core ALU
module alu_muldiv_seq #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          div,
    input  logic [DW-1:0] opa,
    input  logic [DW-1:0] opb,
    input  logic          abort,
    input  logic          rdy,
    output logic          busy,
    output logic          done,
    output logic          dz,
    output logic [DW-1:0] result_hi,
    output logic [DW-1:0] result_lo,
    alu_muldiv_seq_if.master alu
);
    localparam int CW = $clog2(DW) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    r_state;
    logic [DW-1:0] r_h;
    logic [DW-1:0] r_l;
    logic [DW-1:0] r_m;
    logic [CW-1:0] r_cnt;
    logic          r_mode;
    logic [DW-1:0] r_result_hi;
    logic [DW-1:0] r_result_lo;
    logic          r_dz;

    logic [DW:0]   w_s;
    logic          w_q;
    logic          w_issue;
    logic          w_alu_rdy;
    logic [DW-1:0] w_h_next;
    logic [DW-1:0] w_l_next;
    logic [CW-1:0] w_cnt_next;

    // Divide works on the partial remainder shifted left by one with the next dividend bit.
    assign w_s        = {r_h, r_l[DW-1]};
    assign w_q        = w_s[DW] | alu.alu_co;
    assign w_issue    = (r_state == S_ISSUE);
    assign w_alu_rdy  = w_issue & rdy & alu.alu_gnt;
    assign w_cnt_next = r_cnt - CW'(1);

    always_comb begin
        w_h_next = r_h;
        w_l_next = r_l;
        if (r_mode) begin
            w_h_next = w_q ? alu.alu_out : w_s[DW-1:0];
            w_l_next = {r_l[DW-2:0], w_q};
        end else begin
            w_h_next = {alu.alu_co, alu.alu_out[DW-1:1]};
            w_l_next = {alu.alu_out[0], r_l[DW-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_h         <= '0;
            r_l         <= '0;
            r_m         <= '0;
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_result_hi <= '0;
            r_result_lo <= '0;
            r_dz        <= 1'b0;
        end else if (abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= div;
                        if (div && (opb == '0)) begin
                            r_result_hi <= opa;
                            r_result_lo <= '1;
                            r_dz        <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_h     <= '0;
                            r_l     <= opa;
                            r_m     <= opb;
                            r_cnt   <= CW'(DW);
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (alu.alu_gnt) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_alu_rdy) begin
                        r_state <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    r_h   <= w_h_next;
                    r_l   <= w_l_next;
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == '0) begin
                        r_result_hi <= w_h_next;
                        r_result_lo <= w_l_next;
                        r_dz        <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        alu.alu_op = 4'b0011;
        alu.alu_ai = '0;
        alu.alu_bi = '0;
        alu.alu_ci = 1'b0;
        if (w_issue) begin
            if (r_mode) begin
                alu.alu_op = 4'b0111;
                alu.alu_ai = w_s[DW-1:0];
                alu.alu_bi = r_m;
                alu.alu_ci = 1'b1;
            end else begin
                alu.alu_ai = r_h;
                alu.alu_bi = r_l[0] ? r_m : '0;
            end
        end
    end

    assign alu.alu_req    = (r_state == S_REQ) | w_issue | (r_state == S_CAPT);
    assign alu.alu_rdy    = w_alu_rdy;
    assign alu.alu_right  = 1'b0;
    assign alu.alu_rotate = 1'b0;
    assign alu.alu_ei     = 4'b0000;

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign dz        = r_dz;
    assign result_hi = r_result_hi;
    assign result_lo = r_result_lo;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - directed self-checking bench for alu_muldiv_seq with a registered ALU model
module tb_alu_muldiv_seq;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          div;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          abort;
    logic          rdy;
    logic          busy;
    logic          done;
    logic          dz;
    logic [DW-1:0] result_hi;
    logic [DW-1:0] result_lo;

    int n_cmp = 0;
    int n_bad = 0;
    int viol = 0;
    int done_cnt = 0;
    int req_cnt = 0;

    alu_muldiv_seq_if #(.DW(DW)) alu_bus ();

    alu_muldiv_seq #(.DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .div       (div),
        .opa       (opa),
        .opb       (opb),
        .abort     (abort),
        .rdy       (rdy),
        .busy      (busy),
        .done      (done),
        .dz        (dz),
        .result_hi (result_hi),
        .result_lo (result_lo),
        .alu       (alu_bus)
    );

    always #5 clk = ~clk;

    logic [DW:0] w_sum;
    always_comb begin
        w_sum = {1'b0, alu_bus.alu_ai}
              + {1'b0, (alu_bus.alu_op == 4'b0111) ? ~alu_bus.alu_bi : alu_bus.alu_bi}
              + {{DW{1'b0}}, alu_bus.alu_ci};
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            alu_bus.alu_out <= '0;
            alu_bus.alu_co  <= 1'b0;
        end else if (alu_bus.alu_rdy) begin
            alu_bus.alu_out <= w_sum[DW-1:0];
            alu_bus.alu_co  <= w_sum[DW];
        end
    end

    always @(negedge clk) begin
        if (alu_bus.alu_rdy && !alu_bus.alu_gnt) viol++;
        if (done) done_cnt++;
        if (alu_bus.alu_req) req_cnt++;
    end

    task automatic run_op(input logic d, input logic [DW-1:0] a, input logic [DW-1:0] b, output int cyc);
        @(negedge clk);
        start = 1'b1; div = d; opa = a; opb = b;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL op_timeout cycles=%0d no done seen", cyc);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; div = 1'b0; opa = '0; opb = '0;
        abort = 1'b0; rdy = 1'b1; alu_bus.alu_gnt = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags busy=%b done=%b dz=%b exp 000", busy, done, dz); end
        n_cmp++; if (result_hi !== 16'h0000 || result_lo !== 16'h0000) begin
            n_bad++; $display("FAIL reset_results got %h_%h exp 0000_0000", result_hi, result_lo); end
        n_cmp++; if (alu_bus.alu_req !== 1'b0 || alu_bus.alu_rdy !== 1'b0 || alu_bus.alu_op !== 4'b0011) begin
            n_bad++; $display("FAIL reset_alu req=%b rdy=%b op=%b exp 0 0 0011",
                              alu_bus.alu_req, alu_bus.alu_rdy, alu_bus.alu_op); end
        n_cmp++; if (alu_bus.alu_ai !== 16'h0 || alu_bus.alu_bi !== 16'h0 || alu_bus.alu_ci !== 1'b0) begin
            n_bad++; $display("FAIL reset_alu_in ai=%h bi=%h ci=%b exp 0", alu_bus.alu_ai, alu_bus.alu_bi, alu_bus.alu_ci); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_op(input logic d, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] eh, input logic [DW-1:0] el, input int ecyc);
        int cyc;
        run_op(d, a, b, cyc);
        n_cmp++; if (cyc !== ecyc) begin
            n_bad++; $display("FAIL op_latency %h/%h div=%b got %0d exp %0d", a, b, d, cyc, ecyc); end
        n_cmp++; if (result_hi !== eh) begin
            n_bad++; $display("FAIL op_hi %h/%h div=%b got %h exp %h", a, b, d, result_hi, eh); end
        n_cmp++; if (result_lo !== el) begin
            n_bad++; $display("FAIL op_lo %h/%h div=%b got %h exp %h", a, b, d, result_lo, el); end
        n_cmp++; if (dz !== 1'b0) begin
            n_bad++; $display("FAIL op_dz %h/%h div=%b got %b exp 0", a, b, d, dz); end
    endtask

    task automatic test_div_zero;
        int cyc;
        int rc;
        rc = req_cnt;
        run_op(1'b1, 16'h1234, 16'h0000, cyc);
        n_cmp++; if (cyc !== 1) begin
            n_bad++; $display("FAIL dz_latency got %0d exp 1", cyc); end
        n_cmp++; if (dz !== 1'b1 || result_lo !== 16'hFFFF || result_hi !== 16'h1234) begin
            n_bad++; $display("FAIL dz_result dz=%b got %h_%h exp 1 1234_ffff", dz, result_hi, result_lo); end
        repeat (2) @(negedge clk);
        n_cmp++; if (req_cnt !== rc) begin
            n_bad++; $display("FAIL dz_no_req req cycles got %0d exp 0", req_cnt - rc); end
    endtask

    task automatic test_stall;
        int c;
        int gl;
        int ph;
        viol = 0;
        alu_bus.alu_gnt = 1'b0;
        @(negedge clk);
        start = 1'b1; div = 1'b0; opa = 16'h1234; opb = 16'h5678;
        @(posedge clk);
        c = 1; gl = 0; ph = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && c < 300) begin
            if (ph == 0 && c >= 6) alu_bus.alu_gnt = 1'b1;
            if (ph == 0 && c >= 10 && alu_bus.alu_rdy) begin
                alu_bus.alu_gnt = 1'b0; gl = 2; ph = 1;
            end else if (ph == 1) begin
                if (gl > 0) gl--;
                else begin alu_bus.alu_gnt = 1'b1; ph = 2; end
            end else if (ph == 2 && c >= 20 && alu_bus.alu_rdy) begin
                rdy = 1'b0; ph = 3;
            end else if (ph == 3) begin
                rdy = 1'b1; ph = 4;
            end
            @(posedge clk);
            c++;
            @(negedge clk);
        end
        alu_bus.alu_gnt = 1'b1; rdy = 1'b1;
        n_cmp++; if (c !== 43 || !done) begin
            n_bad++; $display("FAIL stall_latency got %0d done=%b exp 43", c, done); end
        n_cmp++; if (result_hi !== 16'h0626 || result_lo !== 16'h0060) begin
            n_bad++; $display("FAIL stall_result got %h_%h exp 0626_0060", result_hi, result_lo); end
        n_cmp++; if (viol !== 0) begin
            n_bad++; $display("FAIL stall_rdy_without_gnt got %0d cycles exp 0", viol); end
    endtask

    task automatic test_abort;
        int iter;
        int dn;
        @(negedge clk);
        start = 1'b1; div = 1'b1; opa = 16'h8000; opb = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        iter = 0;
        for (int c = 0; c < 100; c++) begin
            if (alu_bus.alu_rdy) iter++;
            if (iter == 7) break;
            @(negedge clk);
        end
        abort = 1'b1;
        dn = done_cnt;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0 || alu_bus.alu_req !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL abort_idle busy=%b req=%b done=%b exp 000", busy, alu_bus.alu_req, done); end
        n_cmp++; if (result_hi !== 16'h0001 || result_lo !== 16'h2492) begin
            n_bad++; $display("FAIL abort_results got %h_%h exp 0001_2492", result_hi, result_lo); end
        repeat (40) @(negedge clk);
        n_cmp++; if (done_cnt !== dn) begin
            n_bad++; $display("FAIL abort_no_done got %0d done cycles exp 0", done_cnt - dn); end
        start = 1'b1; abort = 1'b1; div = 1'b0; opa = 16'h0003; opb = 16'h0005;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin
            n_bad++; $display("FAIL abort_with_start busy got %b exp 0", busy); end
    endtask

    task automatic test_busy_start;
        int c;
        @(negedge clk);
        start = 1'b1; div = 1'b0; opa = 16'h0003; opb = 16'h0005;
        @(posedge clk);
        c = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && c < 200) begin
            if (c == 5) begin start = 1'b1; div = 1'b1; opa = 16'h1234; opb = 16'h0000; end
            else start = 1'b0;
            @(posedge clk);
            c++;
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++; if (c !== 34 || !done) begin
            n_bad++; $display("FAIL busy_start_latency got %0d done=%b exp 34", c, done); end
        n_cmp++; if (result_hi !== 16'h0000 || result_lo !== 16'h000F || dz !== 1'b0) begin
            n_bad++; $display("FAIL busy_start_result got %h_%h dz=%b exp 0000_000f 0", result_hi, result_lo, dz); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1'b1; div = 1'b1; opa = 16'hFFFF; opb = 16'h0007;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0 || alu_bus.alu_req !== 1'b0 || alu_bus.alu_rdy !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_flags busy=%b done=%b dz=%b req=%b rdy=%b exp 0",
                              busy, done, dz, alu_bus.alu_req, alu_bus.alu_rdy); end
        n_cmp++; if (result_hi !== 16'h0 || result_lo !== 16'h0 || alu_bus.alu_op !== 4'b0011 ||
                     alu_bus.alu_ai !== 16'h0 || alu_bus.alu_bi !== 16'h0 || alu_bus.alu_ci !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_values res=%h_%h op=%b ai=%h bi=%h ci=%b exp 0 0011 0",
                              result_hi, result_lo, alu_bus.alu_op, alu_bus.alu_ai, alu_bus.alu_bi, alu_bus.alu_ci); end
        @(negedge clk);
        reset_n = 1'b1;
        test_op(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 34);
    endtask

    initial begin
        test_reset();
        test_op(1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 34);
        test_op(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 34);
        test_op(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 34);
        test_div_zero();
        test_stall();
        test_op(1'b1, 16'hFFFF, 16'h0007, 16'h0001, 16'h2492, 34);
        test_abort();
        test_busy_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
